// File: rtl/kv32_ifu.sv
// kv32_ifu: instruction-fetch unit for the kv32 pipeline.
//
// Issues word fetches to instruction memory over a valid/ready request
// channel with up to MAX_OUTSTANDING requests in flight, collects in-order
// responses into a FIFO_DEPTH-entry prefetch FIFO, and presents the FIFO head
// to decode together with its PC. A redirect from execute reloads the fetch
// PC, flushes the FIFO and marks every in-flight response as stale.
//
// Optional build macro: KV32_IFU_BYPASS_EN
//   When defined, a response arriving while the FIFO is empty (and nothing is
//   being dropped or redirected) is presented to decode in the same cycle and
//   skips the FIFO if decode takes it. When undefined, every instruction goes
//   through the FIFO and there is no combinational response->decode path.
//
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   fetch_en           allow new memory requests
//   redirect_valid     one-cycle redirect strobe from execute
//   redirect_target    new fetch PC (bits [1:0] ignored)
//   imem_req_valid/ready/addr   fetch request channel
//   imem_rsp_valid/data         in-order response, no backpressure
//   instr_valid/ready           decode handshake on the FIFO head
//   instr_data, instr_pc, instr_pc_p4   head instruction, its PC, PC+4
//   busy               requests in flight or FIFO non-empty
module kv32_ifu #(
    parameter int          FIFO_DEPTH      = 4,
    parameter int          MAX_OUTSTANDING = 2,
    parameter logic [31:0] RESET_PC        = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fetch_en,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr_data,
    output logic [31:0] instr_pc,
    output logic [31:0] instr_pc_p4,
    output logic        busy
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam logic [CW:0]   DEPTH_W  = (CW + 1)'(FIFO_DEPTH);
    localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0] MAXO_C   = CW'(MAX_OUTSTANDING);
    localparam logic [CW-1:0] ONE_C    = CW'(1);
    localparam logic [TW-1:0] TAG_LAST = TW'(MAX_OUTSTANDING - 1);

    logic [31:0]   pc_q, pc_d;
    logic [CW-1:0] out_q, out_d;
    logic [CW-1:0] drop_q, drop_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [TW-1:0] tag_rd_q, tag_rd_d, tag_wr_q, tag_wr_d;
    logic [31:0]   fifo_data_q [FIFO_DEPTH];
    logic [31:0]   fifo_pc_q   [FIFO_DEPTH];
    logic [31:0]   tag_q       [MAX_OUTSTANDING];

    logic          req_fire, rsp_keep, fifo_empty, pop, push;
    logic [CW:0]   credit_used;
    logic [31:0]   rsp_pc;

    // Every slot the FIFO may eventually need is reserved at issue time;
    // stale (to-be-dropped) responses hand their reservation back.
    assign credit_used    = {1'b0, cnt_q} + {1'b0, out_q} - {1'b0, drop_q};
    assign imem_req_valid = fetch_en & ~redirect_valid & ~rst
                          & (out_q < MAXO_C) & (credit_used < DEPTH_W);
    assign imem_req_addr  = pc_q;
    assign req_fire       = imem_req_valid & imem_req_ready;

    assign fifo_empty = (cnt_q == '0);
    assign rsp_pc     = tag_q[tag_rd_q];
    assign rsp_keep   = imem_rsp_valid & ~redirect_valid & (drop_q == '0);
    assign pop        = ~fifo_empty & instr_ready & ~redirect_valid;

`ifdef KV32_IFU_BYPASS_EN
    logic byp_active;
    assign byp_active  = rsp_keep & fifo_empty;
    assign instr_valid = ~fifo_empty | byp_active;
    assign instr_data  = fifo_empty ? imem_rsp_data : fifo_data_q[rd_ptr_q];
    assign instr_pc    = fifo_empty ? rsp_pc : fifo_pc_q[rd_ptr_q];
    // A bypassed word taken by decode never occupies a FIFO slot.
    assign push        = rsp_keep & ~(byp_active & instr_ready);
`else
    assign instr_valid = ~fifo_empty;
    assign instr_data  = fifo_data_q[rd_ptr_q];
    assign instr_pc    = fifo_pc_q[rd_ptr_q];
    assign push        = rsp_keep;
`endif

    assign instr_pc_p4 = instr_pc + 32'd4;
    assign busy        = (out_q != '0) | ~fifo_empty;

    always_comb begin
        pc_d     = pc_q;
        out_d    = out_q + CW'(req_fire) - CW'(imem_rsp_valid);
        drop_d   = drop_q;
        cnt_d    = cnt_q + CW'(push) - CW'(pop);
        rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        tag_wr_d = tag_wr_q;
        tag_rd_d = tag_rd_q;

        // Tag queue tracks every request, stale or not, so it is never flushed.
        if (req_fire)
            tag_wr_d = (tag_wr_q == TAG_LAST) ? '0 : tag_wr_q + TW'(1);
        if (imem_rsp_valid)
            tag_rd_d = (tag_rd_q == TAG_LAST) ? '0 : tag_rd_q + TW'(1);

        if (redirect_valid) begin
            pc_d     = redirect_target & ~32'h3;
            // Everything still in flight after this cycle belongs to the old stream.
            drop_d   = out_q - CW'(imem_rsp_valid);
            cnt_d    = '0;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
        end else begin
            if (req_fire)
                pc_d = pc_q + 32'd4;
            if (imem_rsp_valid && (drop_q != '0))
                drop_d = drop_q - ONE_C;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q     <= RESET_PC;
            out_q    <= '0;
            drop_q   <= '0;
            cnt_q    <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            tag_rd_q <= '0;
            tag_wr_q <= '0;
        end else begin
            pc_q     <= pc_d;
            out_q    <= out_d;
            drop_q   <= drop_d;
            cnt_q    <= cnt_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            tag_rd_q <= tag_rd_d;
            tag_wr_q <= tag_wr_d;
        end
    end

    // Storage arrays carry no reset; validity comes from the counters.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_data_q[wr_ptr_q] <= imem_rsp_data;
            fifo_pc_q[wr_ptr_q]   <= rsp_pc;
        end
        if (req_fire)
            tag_q[tag_wr_q] <= pc_q;
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(push && !pop && (cnt_q == DEPTH_C)));
    a_no_orphan_rsp: assert property (@(posedge clk) disable iff (rst)
        !(imem_rsp_valid && (out_q == '0)));
endmodule

// File: doc/kv32_ifu.md
Name: kv32_ifu

Overview:
Parametrised instruction-fetch unit for the next-generation kv32 pipeline. It replaces the fixed one-cycle PC/IMEM coupling with these pieces:
- a valid/ready IMEM request/response interface with several requests in flight;
- a prefetch FIFO that feeds the decode stage;
- redirect handling that flushes stale instructions.

It sits between the instruction memory and the decode stage. It takes branch/jump redirects from the execute stage.

Parameters:
FIFO_DEPTH, 4, prefetch FIFO entries (power of two, >=2)
MAX_OUTSTANDING, 2, max IMEM requests in flight (1..FIFO_DEPTH)
RESET_PC, 32'h0000_0000, first fetch address after reset (word aligned)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
fetch_en  in  1  allow new IMEM requests
redirect_valid  in  1  execute-stage redirect strobe
redirect_target  in  32  new PC; bits [1:0] ignored
imem_req_valid  out  1  fetch request
imem_req_ready  in  1  memory accepts request
imem_req_addr  out  32  fetch address
imem_rsp_valid  in  1  in-order response strobe, no backpressure
imem_rsp_data  in  32  instruction word
instr_valid  out  1  FIFO head valid
instr_ready  in  1  decode consumes head
instr_data  out  32  instruction
instr_pc  out  32  address of instr_data
instr_pc_p4  out  32  instr_pc + 4
busy  out  1  outstanding != 0 or FIFO non-empty

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (rst).
- Reset values:
  - fetch pc = RESET_PC.
  - FIFO empty, outstanding = 0, drop_cnt = 0.
  - imem_req_valid = 0, instr_valid = 0, busy = 0.
  - Data outputs are don't-care while their valid signal is 0.
- The IMEM side is reset by the same rst. No response may arrive for a request issued before reset.
- Request issue condition: imem_req_valid = fetch_en & !redirect_valid & !rst & (outstanding < MAX_OUTSTANDING) & (fifo_count + outstanding - drop_cnt < FIFO_DEPTH).
  - imem_req_addr = pc, driven combinationally from the pc register.
  - On request handshake: pc <= pc + 4 (mod 2^32, wraps FFFF_FFFC -> 0) and outstanding++.
- Response handling: on each imem_rsp_valid, outstanding-- (same cycle as a new handshake gives net 0).
  - If drop_cnt > 0: discard the response and drop_cnt--.
  - Otherwise: push {data, pc_of_request} into the FIFO.
  - The credit rule guarantees a push never overflows. An overflow is an assertion failure.
- Per-request PC tracking: a MAX_OUTSTANDING-deep PC tag queue, pushed on request handshake and popped on response.
- Decode side:
  - instr_* reflect the FIFO head, registered (no combinational path from imem_rsp_*).
  - Pop on instr_valid & instr_ready.
  - Push and pop in the same cycle are legal when the FIFO is full or empty+bypass.
- Redirect (single cycle, highest priority):
  - pc <= {redirect_target[31:2],2'b00}.
  - FIFO cleared; any pop that cycle is ignored.
  - No request issued that cycle.
  - drop_cnt <= outstanding - (imem_rsp_valid ? 1 : 0). Any response arriving in the redirect cycle is discarded.
  - outstanding updates normally.
  - First request to the new target is issued no earlier than the next cycle.
- Back-to-back redirects: each one recomputes drop_cnt from the current outstanding. The last target wins.
- fetch_en = 0: no new requests. In-flight responses still complete and fill the FIFO, and decode may drain it.
- Steady-state throughput: one instruction/cycle when memory latency <= MAX_OUTSTANDING and decode is always ready.
- Minimum request-to-instr_valid latency: memory latency + 1 cycle (FIFO write).

Optional Feature:
KV32_IFU_BYPASS_EN
- Defined: when the FIFO is empty, drop_cnt = 0, no redirect, and imem_rsp_valid = 1, the response drives instr_* combinationally in the same cycle.
  - If instr_ready = 1, it is consumed and not written to the FIFO.
  - Otherwise it is written as normal.
- Undefined: every instruction passes through the FIFO (minimum +1 cycle). No combinational rsp -> instr path exists.

Test Plan:
- Reset, fetch_en = 1, 1-cycle memory, instr_ready = 1 -> requests at 0,4,8,...; instr_pc 0,4,8,... one per cycle after the pipeline fills; instr_pc_p4 = instr_pc + 4.
- instr_ready = 0, memory latency 1, FIFO_DEPTH = 4 -> exactly 4 requests issued, then imem_req_valid = 0. Raise instr_ready -> instr_pc 0,4,8,C in order, and fetching resumes at 0x10.
- 3-cycle memory latency, 2 requests outstanding (0x20, 0x24), redirect_target = 0x103 -> responses for 0x20/0x24 discarded. Next request address = 0x100, and the first instr_pc after the redirect = 0x100.
- Redirect in the same cycle as instr handshake and imem_rsp_valid -> the FIFO is empty the next cycle, the response is dropped, and drop_cnt = outstanding - 1.
- imem_req_ready held 0 for 5 cycles at pc = 0x40 -> imem_req_addr stable at 0x40 and pc does not advance. Redirect in that window -> imem_req_addr = target on the next cycle.
- RESET_PC = 32'hFFFF_FFF8 -> fetch addresses FFFF_FFF8, FFFF_FFFC, 0000_0000. Assert rst mid-stream with 2 outstanding -> all outputs return to their reset values in the next cycle.
